// File: rtl/i_sram_pkg.sv
// Shared constants and loader state encoding for the I SRAM write path.
package i_sram_pkg;
  localparam int IMEM_WORD_W    = 48;
  localparam int IMEM_WORDS_ROW = 5;
  localparam int IMEM_ROW_W     = IMEM_WORD_W * IMEM_WORDS_ROW;
  localparam int IMEM_ADDR_W    = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_e;
endpackage

// File: rtl/i_sram_loader_row_packer.sv
// Packs NUM_LANES stream words into one row, lane 0 in the LSBs.
module row_packer
  import i_sram_pkg::*;
#(
  parameter int NUM_LANES = IMEM_WORDS_ROW,
  parameter int VEC_W     = IMEM_WORD_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_beat,
  input  logic [VEC_W-1:0]           i_data,
  output logic                       o_row_full_pulse,
  output logic [NUM_LANES*VEC_W-1:0] o_row
);
  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][VEC_W-1:0] r_row;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_row;
  logic [IDX_W-1:0]                r_word_idx;

  // w_row already carries the incoming beat so the last word lands in the
  // row handed to the write register on the same edge.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_row[g] = (i_beat && r_word_idx == IDX_W'(g)) ? i_data : r_row[g];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row      <= '0;
      r_word_idx <= '0;
    end else if (i_beat) begin
      r_row      <= w_row;
      r_word_idx <= (r_word_idx == LAST) ? '0 : r_word_idx + 1'b1;
    end
  end

  assign o_row_full_pulse = i_beat && (r_word_idx == LAST);
  assign o_row            = w_row;
endmodule

// File: rtl/i_sram_loader.sv
// I SRAM write front end: packs 48-bit stream words into 240-bit rows and
// issues one write per complete row from a programmed base address.
module i_sram_loader
  import i_sram_pkg::*;
#(
  parameter int WORD_W    = IMEM_WORD_W,
  parameter int WORDS_ROW = IMEM_WORDS_ROW,
  parameter int ADDR_W    = IMEM_ADDR_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             row_count,
  input  logic                        s_valid,
  input  logic [WORD_W-1:0]           s_data,
  output logic                        s_ready,
  output logic                        iMem_WEPin,
  output logic [ADDR_W-1:0]           iMem_WEAddress,
  output logic [WORD_W*WORDS_ROW-1:0] idataWrite,
  output logic                        busy,
  output logic                        done
);
  ld_state_e                   r_state, w_state_nxt;
  logic [ADDR_W-1:0]           r_addr;
  logic [ADDR_W:0]             r_rows_left;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_waddr;
  logic [WORD_W*WORDS_ROW-1:0] r_wdata;
  logic                        w_beat, w_full, w_accept;
  logic [WORD_W*WORDS_ROW-1:0] w_row;

  assign s_ready  = (r_state == LOAD);
  assign w_beat   = s_valid && s_ready;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);

  row_packer #(.NUM_LANES(WORDS_ROW), .VEC_W(WORD_W)) u_packer (
    .clock            (clock),
    .reset            (reset),
    .i_beat           (w_beat),
    .i_data           (s_data),
    .o_row_full_pulse (w_full),
    .o_row            (w_row)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_accept) w_state_nxt = (row_count == '0) ? DONE : LOAD;
      LOAD:       if (w_full && r_rows_left == (ADDR_W+1)'(1)) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_rows_left <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_full;
      if (w_accept) begin
        r_addr      <= base_addr;
        r_rows_left <= row_count;
      end
      // Write register is separate from the packer, so the next row's beats
      // keep flowing during the write cycle. Address wraps naturally.
      if (w_full) begin
        r_waddr     <= r_addr;
        r_wdata     <= w_row;
        r_addr      <= r_addr + 1'b1;
        r_rows_left <= r_rows_left - 1'b1;
      end
    end
  end

  assign iMem_WEPin     = r_we;
  assign iMem_WEAddress = r_waddr;
  assign idataWrite     = r_wdata;
  assign busy           = (r_state == LOAD);
  assign done           = (r_state == DONE);
endmodule

// File: tb/tb_i_sram_loader.sv
// Scoreboard bench for i_sram_loader: expected writes are queued as stimulus
// is issued and a negedge monitor pops/compares on every WE pulse.
module tb_i_sram_loader;
  import i_sram_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   base_addr = '0;
  logic [8:0]   row_count = '0;
  logic         s_valid = 1'b0;
  logic [47:0]  s_data = '0;
  logic         s_ready, iMem_WEPin, busy, done;
  logic [7:0]   iMem_WEAddress;
  logic [239:0] idataWrite;

  i_sram_loader dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .row_count(row_count), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .iMem_WEPin(iMem_WEPin), .iMem_WEAddress(iMem_WEAddress),
    .idataWrite(idataWrite), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   addr;
    logic [239:0] data;
    logic         done;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           we_cnt = 0;
  int           we_t[$];
  logic [239:0] sram [256];
  bit           seen [256];
  logic [239:0] stream_rows [4];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [239:0] act, input logic [239:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every WE must match the oldest expected write.
  always @(negedge clock) begin
    if (iMem_WEPin === 1'b1) begin
      we_cnt++;
      we_t.push_back(cyc);
      sram[iMem_WEAddress] = idataWrite;
      seen[iMem_WEAddress] = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we addr=%h", iMem_WEAddress);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_addr", 240'(iMem_WEAddress), 240'(mon_e.addr));
        chk("we_data", idataWrite, mon_e.data);
        chk("we_done", 240'(done), 240'(mon_e.done));
      end
    end
  end

  function automatic logic [47:0] word_of(input int seed, input int r, input int k);
    return {8'(seed), 24'(r), 16'(k)};
  endfunction

  function automatic logic [239:0] row_of(input int seed, input int r);
    logic [239:0] row;
    row = '0;
    for (int k = 0; k < 5; k++) row[48*k +: 48] = word_of(seed, r, k);
    return row;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; row_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [47:0] d);
    chk("s_ready", 240'(s_ready), 240'(1));
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  // Streams n rows; expected write is queued just before the beat that completes it.
  task automatic run_rows(input logic [7:0] b, input int n, input int seed,
                          input int maxgap, input bit busy_start);
    wr_t e;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 5; k++) begin
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        if (maxgap > 0 && r == 1 && k == 2) repeat (12) tick();
        if (busy_start && r == 0 && k == 3) begin
          start = 1'b1; base_addr = 8'h50; row_count = 9'd1;
          tick();
          start = 1'b0;
          chk("busy_after_start", 240'(busy), 240'(1));
        end
        if (k == 4) begin
          e.addr = 8'(b + r[7:0]);
          e.data = row_of(seed, r);
          e.done = (r == n - 1);
          exp_q.push_back(e);
        end
        beat(word_of(seed, r, k));
      end
    end
  endtask

  task automatic chk_idle_done();
    chk("done_end", 240'(done), 240'(1));
    chk("busy_end", 240'(busy), 240'(0));
    chk("s_ready_end", 240'(s_ready), 240'(0));
  endtask

  initial begin
    int cnt0;
    int nseen;
    wr_t e;

    // Reset values
    #1;
    chk("rst_we", 240'(iMem_WEPin), 240'(0));
    chk("rst_addr", 240'(iMem_WEAddress), 240'(0));
    chk("rst_data", idataWrite, 240'(0));
    chk("rst_flags", 240'({s_ready, busy, done}), 240'(0));
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single row, words 1..5
    do_start(8'h10, 9'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        e.addr = 8'h10;
        e.data = {48'd5, 48'd4, 48'd3, 48'd2, 48'd1};
        e.done = 1'b1;
        exp_q.push_back(e);
      end
      beat(48'(k + 1));
    end
    tick();
    chk_idle_done();

    // Streaming with valid held high
    we_t.delete();
    do_start(8'h00, 9'd4);
    run_rows(8'h00, 4, 1, 0, 1'b0);
    tick();
    chk_idle_done();
    chk("stream_we_count", 240'(we_t.size()), 240'(4));
    for (int i = 1; i < 4 && i < we_t.size(); i++)
      chk("we_spacing", 240'(we_t[i] - we_t[i-1]), 240'(5));
    for (int r = 0; r < 4; r++) begin
      chk("readback", sram[r], row_of(1, r));
      stream_rows[r] = sram[r];
      sram[r] = '0;
    end

    // Throttled: same rows as the gap-free run, long stall mid-row
    do_start(8'h00, 9'd4);
    run_rows(8'h00, 4, 1, 3, 1'b0);
    tick();
    chk_idle_done();
    for (int r = 0; r < 4; r++) chk("throttle_vs_stream", sram[r], stream_rows[r]);

    // Wrap FE, FF, 00
    do_start(8'hFE, 9'd3);
    run_rows(8'hFE, 3, 2, 0, 1'b0);
    tick();
    chk_idle_done();

    // Start while busy is ignored
    do_start(8'h20, 9'd2);
    run_rows(8'h20, 2, 3, 0, 1'b1);
    tick();
    chk_idle_done();

    // Reset mid-row drops the partial row
    cnt0 = we_cnt;
    do_start(8'h30, 9'd2);
    for (int k = 0; k < 3; k++) beat(word_of(4, 0, k));
    reset = 1'b0;
    #1;
    chk("midrst_we", 240'(iMem_WEPin), 240'(0));
    chk("midrst_addr", 240'(iMem_WEAddress), 240'(0));
    chk("midrst_data", idataWrite, 240'(0));
    chk("midrst_flags", 240'({s_ready, busy, done}), 240'(0));
    tick(); tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("postrst_flags", 240'({s_ready, busy, done}), 240'(0));
    chk("postrst_no_we", 240'(we_cnt - cnt0), 240'(0));

    // count=0 from IDLE: DONE next cycle, no write
    do_start(8'h99, 9'd0);
    chk("zero_done", 240'(done), 240'(1));
    chk("zero_busy", 240'(busy), 240'(0));
    repeat (4) tick();
    chk("zero_no_we", 240'(we_cnt - cnt0), 240'(0));

    // Packer restarts at word 0 after the reset
    do_start(8'h40, 9'd1);
    run_rows(8'h40, 1, 5, 0, 1'b0);
    tick();
    chk_idle_done();

    // count=256: every address once
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    cnt0 = we_cnt;
    do_start(8'h80, 9'd256);
    run_rows(8'h80, 256, 7, 0, 1'b0);
    tick();
    chk_idle_done();
    nseen = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) nseen++;
    chk("full_we_count", 240'(we_cnt - cnt0), 240'(256));
    chk("full_distinct", 240'(nseen), 240'(256));

    repeat (3) tick();
    chk("queue_empty", 240'(exp_q.size()), 240'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
